// File: rtl/decoder_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational 4-bit -> 14-bit display
// decoder between two requesters and latches each result into a per-channel display register.
module decoder_share_arbiter #(
  parameter int DEC_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [3:0]  val0,
  input  logic        req1,
  input  logic [3:0]  val1,
  output logic [3:0]  dec_in,
  input  logic [13:0] dec_out,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        done0,
  output logic        done1,
  output logic [13:0] disp0,
  output logic [13:0] disp1
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEC_WAIT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       last_served;
  logic       active_ch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
      active_ch   <= 1'b0;
      dec_in      <= '0;
      grant       <= 2'b00;
      busy        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      disp0       <= '0;
      disp1       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // ch0 wins when alone, or when both ask and ch1 was served last
            if (req0 && (!req1 || last_served)) begin
              active_ch <= 1'b0;
              grant     <= 2'b01;
              dec_in    <= val0;
            end else begin
              active_ch <= 1'b1;
              grant     <= 2'b10;
              dec_in    <= val1;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DRIVE;
          end
        end

        DRIVE: begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST) begin
            if (active_ch) begin
              disp1 <= dec_out;
              done1 <= 1'b1;
            end else begin
              disp0 <= dec_out;
              done0 <= 1'b1;
            end
            grant       <= 2'b00;
            last_served <= active_ch;
            state       <= DONE;
          end
        end

        DONE: begin
          // requests are deliberately not sampled here; they are taken next IDLE
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_share_arbiter.sv
// Self-checking bench for decoder_share_arbiter: directed scenarios plus randomized
// traffic against a transaction-timeline reference model; a second DEC_WAIT=1 instance.
module tb_decoder_share_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [3:0]  val0, val1;
  logic [3:0]  dec_in;
  logic [13:0] dec_out;
  logic [1:0]  grant;
  logic        busy, done0, done1;
  logic [13:0] disp0, disp1;

  logic        b_req0, b_req1;
  logic [3:0]  b_val0, b_val1;
  logic [3:0]  b_dec_in;
  logic [13:0] b_dec_out;
  logic [1:0]  b_grant;
  logic        b_busy, b_done0, b_done1;
  logic [13:0] b_disp0, b_disp1;

  assign dec_out   = {10'h2A5, dec_in};
  assign b_dec_out = {10'h2A5, b_dec_in};

  always #5 clk = ~clk;

  decoder_share_arbiter #(.DEC_WAIT(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .val0(val0), .req1(req1), .val1(val1),
    .dec_in(dec_in), .dec_out(dec_out), .grant(grant), .busy(busy),
    .done0(done0), .done1(done1), .disp0(disp0), .disp1(disp1)
  );

  decoder_share_arbiter #(.DEC_WAIT(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0(b_req0), .val0(b_val0), .req1(b_req1), .val1(b_val1),
    .dec_in(b_dec_in), .dec_out(b_dec_out), .grant(b_grant), .busy(b_busy),
    .done0(b_done0), .done1(b_done1), .disp0(b_disp0), .disp1(b_disp1)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each operation is a transaction with a grant edge g; its
  // effects follow from the distance t-g alone.
  int          t;
  bit          m_active;
  int          m_g;
  bit          m_ch;
  bit          m_last;
  logic [3:0]  m_val;
  logic [3:0]  m_dec;
  logic [13:0] m_disp [2];

  task automatic model_reset();
    m_active  = 1'b0;
    m_g       = 0;
    m_ch      = 1'b0;
    m_last    = 1'b1;
    m_val     = 4'h0;
    m_dec     = 4'h0;
    m_disp[0] = 14'h0;
    m_disp[1] = 14'h0;
  endtask

  task automatic model_edge();
    bit ch;
    t++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_active && (t - m_g) == W)
      m_disp[m_ch] = {10'h2A5, m_val};
    if ((!m_active || t >= m_g + W + 2) && (req0 || req1)) begin
      ch       = (req0 && req1) ? !m_last : req1;
      m_ch     = ch;
      m_last   = ch;
      m_g      = t;
      m_val    = ch ? val1 : val0;
      m_dec    = m_val;
      m_active = 1'b1;
    end
  endtask

  task automatic check_all();
    int         d;
    logic [1:0] e_grant;
    logic       e_busy, e_d0, e_d1;
    d       = t - m_g;
    e_grant = (m_active && d < W) ? (m_ch ? 2'b10 : 2'b01) : 2'b00;
    e_busy  = m_active && d <= W;
    e_d0    = m_active && d == W && !m_ch;
    e_d1    = m_active && d == W && m_ch;
    checkOutput("grant",  32'(grant),  32'(e_grant));
    checkOutput("busy",   32'(busy),   32'(e_busy));
    checkOutput("done0",  32'(done0),  32'(e_d0));
    checkOutput("done1",  32'(done1),  32'(e_d1));
    checkOutput("dec_in", 32'(dec_in), 32'(m_dec));
    checkOutput("disp0",  32'(disp0),  32'(m_disp[0]));
    checkOutput("disp1",  32'(disp1),  32'(m_disp[1]));
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next falling edge.
  task automatic applyStimulus(input logic r0, input logic [3:0] v0,
                               input logic r1, input logic [3:0] v1, input logic rn);
    req0    = r0;
    val0    = v0;
    req1    = r1;
    val1    = v1;
    reset_n = rn;
    #1;
    if (!rn) begin
      checkOutput("async_grant", 32'(grant), 32'h0);
      checkOutput("async_busy",  32'(busy),  32'h0);
      checkOutput("async_done",  32'({done1, done0}), 32'h0);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; val0 = 4'h0; val1 = 4'h0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_val0 = 4'h0; b_val1 = 4'h0;
    t = 0;
    model_reset();
    @(negedge clk);

    applyStimulus(0, 4'h0, 0, 4'h0, 0);
    applyStimulus(0, 4'h0, 0, 4'h0, 0);
    checkOutput("reset_disp0", 32'(disp0), 32'h0);

    // Single request on both instances; DEC_WAIT=1 finishes one edge after grant
    b_req0 = 1'b1; b_val0 = 4'h9;
    applyStimulus(1, 4'h9, 0, 4'h0, 1);
    checkOutput("single_grant", 32'(grant), 32'h1);
    checkOutput("b_grant",  32'(b_grant),  32'h1);
    checkOutput("b_dec_in", 32'(b_dec_in), 32'h9);
    checkOutput("b_busy",   32'(b_busy),   32'h1);
    checkOutput("b_done0_early", 32'(b_done0), 32'h0);
    b_req0 = 1'b0;
    applyStimulus(0, 4'h0, 0, 4'h0, 1);
    checkOutput("b_done0", 32'(b_done0), 32'h1);
    checkOutput("b_disp0", 32'(b_disp0), 32'h2A59);
    checkOutput("b_grant_off", 32'(b_grant), 32'h0);
    checkOutput("b_done1", 32'(b_done1), 32'h0);
    checkOutput("b_disp1", 32'(b_disp1), 32'h0);
    applyStimulus(0, 4'h0, 0, 4'h0, 1);
    checkOutput("single_done0", 32'(done0), 32'h1);
    checkOutput("single_disp0", 32'(disp0), 32'h2A59);
    checkOutput("single_disp1", 32'(disp1), 32'h0);
    checkOutput("b_done0_clr", 32'(b_done0), 32'h0);
    checkOutput("b_busy_clr",  32'(b_busy),  32'h0);
    applyStimulus(0, 4'h0, 0, 4'h0, 1);

    // Contention after reset: ch0 first, then strict alternation
    applyStimulus(0, 4'h0, 0, 4'h0, 0);
    applyStimulus(1, 4'h3, 1, 4'hC, 1);
    checkOutput("cont_first", 32'(grant), 32'h1);
    for (int i = 0; i < 3 * (W + 2); i++)
      applyStimulus(1, 4'h3, 1, 4'hC, 1);
    checkOutput("cont_disp0", 32'(disp0), 32'h2A53);
    checkOutput("cont_disp1", 32'(disp1), 32'h2A5C);
    applyStimulus(0, 4'h0, 0, 4'h0, 1);
    applyStimulus(0, 4'h0, 0, 4'h0, 1);
    applyStimulus(0, 4'h0, 0, 4'h0, 1);

    // Value change during DRIVE is ignored
    applyStimulus(0, 4'h0, 1, 4'h5, 1);
    applyStimulus(0, 4'h0, 1, 4'h7, 1);
    applyStimulus(0, 4'h0, 1, 4'h7, 1);
    checkOutput("valchg_disp1", 32'(disp1), 32'h2A55);
    applyStimulus(0, 4'h0, 0, 4'h0, 1);

    // Request dropped after one cycle still completes
    applyStimulus(1, 4'hE, 0, 4'h0, 1);
    for (int i = 0; i < W + 2; i++)
      applyStimulus(0, 4'h0, 0, 4'h0, 1);
    checkOutput("drop_disp0", 32'(disp0), 32'h2A5E);

    // Reset in the middle of DRIVE, then ch0 wins the next contention
    applyStimulus(0, 4'h0, 1, 4'h6, 1);
    applyStimulus(0, 4'h0, 1, 4'h6, 0);
    checkOutput("rst_disp1", 32'(disp1), 32'h0);
    applyStimulus(1, 4'h2, 1, 4'h4, 1);
    checkOutput("rst_then_ch0", 32'(grant), 32'h1);
    for (int i = 0; i < W + 2; i++)
      applyStimulus(0, 4'h0, 0, 4'h0, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(logic'($urandom_range(0, 2) != 0), 4'($urandom),
                    logic'($urandom_range(0, 2) != 0), 4'($urandom),
                    logic'($urandom_range(0, 150) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
